// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detection, 3-sample majority vote at mid-bit,
// and start/parity/stop checking for one 8-bit character with optional parity.
module uart_rx_ctrl (
   input  logic       CLK,
   input  logic       RST,
   input  logic       RX_IN,
   input  logic [5:0] Prescale,
   input  logic       PAR_EN,
   input  logic       PAR_TYP,
   output logic [5:0] edge_cnt,
   output logic       deser_en,
   output logic       sample_bit,
   output logic       data_valid,
   output logic       par_err,
   output logic       stp_err
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t     state_reg;
   logic [3:0] bit_cnt_reg;
   logic       samp0_reg;
   logic       samp1_reg;
   logic       par_acc_reg;
   logic       par_en_reg;
   logic       par_typ_reg;

   logic [5:0] half;
   logic [5:0] mid_lo;
   logic [5:0] mid_hi;
   logic [5:0] edge_last;
   logic       bit_end;
   logic       vote;

   assign half      = {1'b0, Prescale[5:1]};
   assign mid_lo    = half - 6'd1;
   assign mid_hi    = half + 6'd1;
   assign edge_last = Prescale - 6'd1;
   assign bit_end   = (edge_cnt == edge_last);
   // Third sample is taken live on the voting cycle itself.
   assign vote      = (samp0_reg & samp1_reg) | (samp0_reg & RX_IN) | (samp1_reg & RX_IN);
   assign deser_en  = (state_reg == DATA);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_reg   <= IDLE;
         bit_cnt_reg <= 4'd0;
         edge_cnt    <= 6'd0;
         samp0_reg   <= 1'b0;
         samp1_reg   <= 1'b0;
         par_acc_reg <= 1'b0;
         par_en_reg  <= 1'b0;
         par_typ_reg <= 1'b0;
         sample_bit  <= 1'b0;
         data_valid  <= 1'b0;
         par_err     <= 1'b0;
         stp_err     <= 1'b0;
      end else begin
         data_valid <= 1'b0;

         if (state_reg != IDLE) begin
            if (edge_cnt == mid_lo) samp0_reg  <= RX_IN;
            if (edge_cnt == half)   samp1_reg  <= RX_IN;
            if (edge_cnt == mid_hi) sample_bit <= vote;
         end

         case (state_reg)
            IDLE: begin
               edge_cnt    <= 6'd0;
               bit_cnt_reg <= 4'd0;
               // The detection cycle itself is edge 0 of the start bit.
               if (!RX_IN) begin
                  state_reg   <= START;
                  edge_cnt    <= 6'd1;
                  par_en_reg  <= PAR_EN;
                  par_typ_reg <= PAR_TYP;
                  par_err     <= 1'b0;
                  stp_err     <= 1'b0;
               end
            end

            default: begin
               if (bit_end) begin
                  edge_cnt    <= 6'd0;
                  bit_cnt_reg <= bit_cnt_reg + 4'd1;
               end else begin
                  edge_cnt    <= edge_cnt + 6'd1;
               end

               case (state_reg)
                  START: begin
                     if (bit_end) begin
                        if (sample_bit) begin
                           state_reg   <= IDLE;
                           bit_cnt_reg <= 4'd0;
                        end else begin
                           state_reg   <= DATA;
                           par_acc_reg <= 1'b0;
                        end
                     end
                  end

                  DATA: begin
                     if (bit_end) begin
                        par_acc_reg <= par_acc_reg ^ sample_bit;
                        if (bit_cnt_reg == 4'd8) begin
                           state_reg <= par_en_reg ? PARITY : STOP;
                        end
                     end
                  end

                  PARITY: begin
                     if (bit_end) begin
                        par_err   <= par_acc_reg ^ sample_bit ^ par_typ_reg;
                        state_reg <= STOP;
                     end
                  end

                  STOP: begin
                     if (bit_end) begin
                        stp_err     <= ~sample_bit;
                        data_valid  <= sample_bit & ~par_err;
                        state_reg   <= IDLE;
                        bit_cnt_reg <= 4'd0;
                     end
                  end

                  default: ;
               endcase
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: drives whole frames bit by bit and checks
// timing, a downstream deserializer model and the error flags.
module tb_uart_rx_ctrl;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       RX_IN = 1'b1;
   logic [5:0] Prescale = 6'd8;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic [5:0] edge_cnt;
   logic       deser_en;
   logic       sample_bit;
   logic       data_valid;
   logic       par_err;
   logic       stp_err;

   int tests = 0;
   int fails = 0;

   int   gcyc = 0;
   int   dv_q[$];
   int   de_cnt = 0;
   int   de_first = -1;
   int   de_last = -1;
   logic       pe_log [4096];
   logic [5:0] ec_log [4096];
   logic [7:0] p_data = 8'h00;

   uart_rx_ctrl dut (
      .CLK        (CLK),
      .RST        (RST),
      .RX_IN      (RX_IN),
      .Prescale   (Prescale),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .edge_cnt   (edge_cnt),
      .deser_en   (deser_en),
      .sample_bit (sample_bit),
      .data_valid (data_valid),
      .par_err    (par_err),
      .stp_err    (stp_err)
   );

   always #5 CLK = ~CLK;

   // Downstream deserializer: shifts LSB-first on the last edge of each data bit.
   always @(posedge CLK) begin
      if (deser_en && edge_cnt == Prescale - 6'd1)
         p_data <= {sample_bit, p_data[7:1]};
   end

   // One cycle: observe outputs of the current cycle, then drive RX_IN for it.
   task automatic step(input logic rx);
      @(negedge CLK);
      gcyc++;
      if (data_valid) dv_q.push_back(gcyc);
      if (deser_en) begin
         if (de_cnt == 0) de_first = gcyc;
         de_last = gcyc;
         de_cnt++;
      end
      pe_log[gcyc % 4096] = par_err;
      ec_log[gcyc % 4096] = edge_cnt;
      RX_IN = rx;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1);
   endtask

   task automatic clear_log();
      dv_q.delete();
      de_cnt   = 0;
      de_first = -1;
      de_last  = -1;
   endtask

   task automatic send_frame(input int p, input logic pen, input logic ptyp,
                             input logic [7:0] d, input logic parbit,
                             input logic stopbit, input int noise_c, output int t0);
      logic [10:0] b;
      int          nbits;
      logic        rx;
      Prescale = 6'(p);
      PAR_EN   = pen;
      PAR_TYP  = ptyp;
      b        = {stopbit, (pen ? parbit : stopbit), d, 1'b0};
      nbits    = pen ? 11 : 10;
      t0       = gcyc + 1;
      for (int c = 0; c < nbits * p; c++) begin
         rx = b[c / p];
         if (c == noise_c) rx = 1'b0;
         step(rx);
      end
      $display("[TB] frame sent: data=%02h P=%0d par_en=%0b par_bit=%0b stop=%0b t0=%0d",
               d, p, pen, parbit, stopbit, t0);
   endtask

   task automatic test_reset();
      RST = 1'b0;
      repeat (3) @(negedge CLK);
      tests++;
      if ({edge_cnt, deser_en, sample_bit, data_valid, par_err, stp_err} !== 11'b0) begin
         fails++;
         $display("FAIL reset_outputs: got %b expected 0",
                  {edge_cnt, deser_en, sample_bit, data_valid, par_err, stp_err});
      end
      RST = 1'b1;
      idle(4);
      $display("[TB] reset released");
   endtask

   task automatic test_even_parity();
      int t0;
      idle(4);
      clear_log();
      send_frame(8, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, -1, t0);
      idle(8);
      tests++;
      if (de_cnt !== 64) begin fails++; $display("FAIL even_deser_len: got %0d expected 64", de_cnt); end
      tests++;
      if (de_first !== t0 + 8 || de_last !== t0 + 71) begin
         fails++;
         $display("FAIL even_deser_window: got %0d..%0d expected %0d..%0d", de_first, de_last, t0 + 8, t0 + 71);
      end
      tests++;
      if (p_data !== 8'hA5) begin fails++; $display("FAIL even_pdata: got %02h expected a5", p_data); end
      tests++;
      if (dv_q.size() !== 1 || dv_q[0] !== t0 + 88) begin
         fails++;
         $display("FAIL even_dv: got %0d pulses first at %0d expected 1 at %0d",
                  dv_q.size(), (dv_q.size() > 0) ? dv_q[0] : -1, t0 + 88);
      end
      tests++;
      if (par_err !== 1'b0 || stp_err !== 1'b0) begin
         fails++;
         $display("FAIL even_errs: got par=%b stp=%b expected 0 0", par_err, stp_err);
      end
   endtask

   task automatic test_no_parity();
      int t0;
      idle(4);
      clear_log();
      send_frame(16, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, -1, t0);
      idle(8);
      tests++;
      if (dv_q.size() !== 1 || dv_q[0] !== t0 + 160) begin
         fails++;
         $display("FAIL nopar_dv: got %0d pulses first at %0d expected 1 at %0d",
                  dv_q.size(), (dv_q.size() > 0) ? dv_q[0] : -1, t0 + 160);
      end
      tests++;
      if (p_data !== 8'h3C) begin fails++; $display("FAIL nopar_pdata: got %02h expected 3c", p_data); end
      tests++;
      if (de_cnt !== 128) begin fails++; $display("FAIL nopar_deser_len: got %0d expected 128", de_cnt); end
      tests++;
      if (par_err !== 1'b0 || stp_err !== 1'b0) begin
         fails++;
         $display("FAIL nopar_errs: got par=%b stp=%b expected 0 0", par_err, stp_err);
      end
   endtask

   task automatic test_start_glitch();
      int t0;
      Prescale = 6'd8;
      PAR_EN   = 1'b0;
      idle(4);
      clear_log();
      step(1'b0);
      t0 = gcyc;
      step(1'b0);
      idle(38);
      $display("[TB] start glitch sent at t0=%0d", t0);
      tests++;
      if (ec_log[(t0 + 7) % 4096] !== 6'd7) begin
         fails++;
         $display("FAIL glitch_start_edge: got %0d expected 7", ec_log[(t0 + 7) % 4096]);
      end
      tests++;
      if (ec_log[(t0 + 9) % 4096] !== 6'd0) begin
         fails++;
         $display("FAIL glitch_idle_edge: got %0d expected 0", ec_log[(t0 + 9) % 4096]);
      end
      tests++;
      if (de_cnt !== 0 || dv_q.size() !== 0) begin
         fails++;
         $display("FAIL glitch_activity: got deser=%0d dv=%0d expected 0 0", de_cnt, dv_q.size());
      end
      tests++;
      if (par_err !== 1'b0 || stp_err !== 1'b0) begin
         fails++;
         $display("FAIL glitch_errs: got par=%b stp=%b expected 0 0", par_err, stp_err);
      end
   endtask

   task automatic test_parity_error();
      int t0;
      idle(4);
      clear_log();
      send_frame(8, 1'b1, 1'b1, 8'h01, 1'b1, 1'b1, -1, t0);
      idle(8);
      tests++;
      if (pe_log[(t0 + 79) % 4096] !== 1'b0) begin
         fails++;
         $display("FAIL parerr_early: got %b expected 0", pe_log[(t0 + 79) % 4096]);
      end
      tests++;
      if (pe_log[(t0 + 81) % 4096] !== 1'b1 || par_err !== 1'b1) begin
         fails++;
         $display("FAIL parerr_flag: got %b/%b expected 1/1", pe_log[(t0 + 81) % 4096], par_err);
      end
      tests++;
      if (dv_q.size() !== 0 || stp_err !== 1'b0) begin
         fails++;
         $display("FAIL parerr_dv: got dv=%0d stp=%b expected 0 0", dv_q.size(), stp_err);
      end
   endtask

   task automatic test_stop_error();
      int t0;
      idle(4);
      clear_log();
      send_frame(8, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, -1, t0);
      idle(8);
      tests++;
      if (stp_err !== 1'b1) begin fails++; $display("FAIL stperr_flag: got %b expected 1", stp_err); end
      tests++;
      if (dv_q.size() !== 0) begin fails++; $display("FAIL stperr_dv: got %0d pulses expected 0", dv_q.size()); end
      tests++;
      if (par_err !== 1'b0) begin fails++; $display("FAIL stperr_parclear: got %b expected 0", par_err); end
   endtask

   task automatic test_reset_mid();
      int          t0;
      logic [10:0] b;
      Prescale = 6'd8;
      PAR_EN   = 1'b0;
      b        = {1'b1, 1'b1, 8'hC3, 1'b0};
      idle(4);
      clear_log();
      for (int c = 0; c < 28; c++) step(b[c / 8]);
      tests++;
      if (deser_en !== 1'b1) begin fails++; $display("FAIL rstmid_in_data: got %b expected 1", deser_en); end
      #1 RST = 1'b0;
      #1;
      tests++;
      if ({edge_cnt, deser_en, sample_bit, data_valid, par_err, stp_err} !== 11'b0) begin
         fails++;
         $display("FAIL rstmid_outputs: got %b expected 0",
                  {edge_cnt, deser_en, sample_bit, data_valid, par_err, stp_err});
      end
      RX_IN = 1'b1;
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      $display("[TB] reset pulsed mid-frame");
      idle(4);
      clear_log();
      send_frame(8, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, -1, t0);
      idle(8);
      tests++;
      if (dv_q.size() !== 1 || dv_q[0] !== t0 + 80) begin
         fails++;
         $display("FAIL rstmid_next_dv: got %0d pulses first at %0d expected 1 at %0d",
                  dv_q.size(), (dv_q.size() > 0) ? dv_q[0] : -1, t0 + 80);
      end
      tests++;
      if (p_data !== 8'h96) begin fails++; $display("FAIL rstmid_next_pdata: got %02h expected 96", p_data); end
   endtask

   task automatic test_back_to_back();
      int t0a;
      int t0b;
      int gap;
      idle(4);
      clear_log();
      send_frame(32, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, -1, t0a);
      send_frame(32, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b1, -1, t0b);
      idle(40);
      gap = (dv_q.size() == 2) ? dv_q[1] - dv_q[0] : -1;
      tests++;
      if (dv_q.size() !== 2 || gap !== 320) begin
         fails++;
         $display("FAIL b2b_gap: got %0d pulses gap %0d expected 2 pulses gap 320", dv_q.size(), gap);
      end
      tests++;
      if (dv_q.size() < 1 || dv_q[0] !== t0a + 320) begin
         fails++;
         $display("FAIL b2b_first_dv: got %0d expected %0d",
                  (dv_q.size() > 0) ? dv_q[0] : -1, t0a + 320);
      end
      tests++;
      if (p_data !== 8'hAA) begin fails++; $display("FAIL b2b_pdata: got %02h expected aa", p_data); end
   endtask

   task automatic test_noise();
      int t0;
      idle(4);
      clear_log();
      // Low pulse lands on edge P/2 of data bit 0 (frame cycle 16+8).
      send_frame(16, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 24, t0);
      idle(8);
      tests++;
      if (p_data !== 8'h81) begin fails++; $display("FAIL noise_pdata: got %02h expected 81", p_data); end
      tests++;
      if (dv_q.size() !== 1 || stp_err !== 1'b0) begin
         fails++;
         $display("FAIL noise_dv: got %0d pulses stp=%b expected 1 0", dv_q.size(), stp_err);
      end
   endtask

   initial begin
      test_reset();
      test_even_parity();
      test_no_parity();
      test_start_glitch();
      test_parity_error();
      test_stop_error();
      test_reset_mid();
      test_back_to_back();
      test_noise();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
